seq_ma_mul_ctrl: RTL and testbench

//  Iterative shift-add multiplier sequencer: a single WIDTH-bit multiply-accumulate row
//  (AND-gated multiplicand + partial sum + carry) is reused for WIDTH cycles, instead of

---
 rtl/seq_ma_mul_ctrl.sv | 98 +++++++++
 tb/tb_seq_ma_mul_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/seq_ma_mul_ctrl.sv
// Iterative shift-add multiplier sequencer.
// A single WIDTH-bit multiply-accumulate row is reused once per cycle for WIDTH cycles.
// Operands arrive over a valid/ready handshake, and the product leaves over another one.
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | ready for an operand pair; in_ready_o=1
// RUN   | one row step per edge; cnt_q counts completed steps
// DONE  | product held on out_o with out_valid_o=1 until out_ready_i
module seq_ma_mul_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [WIDTH-1:0]     in_a_i,
    input  logic [WIDTH-1:0]     in_b_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [2*WIDTH-1:0]   out_o
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   a_q;
    logic [2*WIDTH-1:0] p_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               in_ready_q;
    logic               out_valid_q;

    logic [WIDTH:0]     row_sum;
    logic [2*WIDTH-1:0] p_step;

    // One multiply-accumulate row: add the gated multiplicand to the upper half, then shift right
    always_comb begin
        row_sum = {1'b0, p_q[2*WIDTH-1:WIDTH]} + ({1'b0, a_q} & {(WIDTH+1){p_q[0]}});
        p_step  = {row_sum, p_q[WIDTH-1:1]};
    end

    // Sequencer state, datapath registers, and registered handshake outputs
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            p_q         <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid_i) begin
                        a_q        <= in_a_i;
                        p_q        <= {{WIDTH{1'b0}}, in_b_i};
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    p_q   <= p_step;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // P is left untouched so out_o keeps the last product after handoff
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_o       = p_q;

endmodule

// File: tb/tb_seq_ma_mul_ctrl.sv
// Directed and sweep bench for seq_ma_mul_ctrl.
// Two instances are used: WIDTH=4 for the directed tests and the exhaustive sweep, and WIDTH=8 for a random sweep.
module tb_seq_ma_mul_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       in_valid, in_ready, out_valid, out_ready;
    logic [3:0] in_a, in_b;
    logic [7:0] out_p;

    logic        in_valid8, in_ready8, out_valid8, out_ready8;
    logic [7:0]  in_a8, in_b8;
    logic [15:0] out_p8;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_ma_mul_ctrl #(.WIDTH(4)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_a_i      (in_a),
        .in_b_i      (in_b),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_o       (out_p)
    );

    seq_ma_mul_ctrl #(.WIDTH(8)) dut8 (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .in_valid_i  (in_valid8),
        .in_ready_o  (in_ready8),
        .in_a_i      (in_a8),
        .in_b_i      (in_b8),
        .out_valid_o (out_valid8),
        .out_ready_i (out_ready8),
        .out_o       (out_p8)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One WIDTH=4 transaction with `stall` cycles of backpressure in DONE
    task automatic run4(input int a, input int b, input int stall, input string tag);
        int n;
        in_a = 4'(a); in_b = 4'(b); in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        in_a = 4'($urandom); in_b = 4'($urandom);
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        chk({tag, " latency"}, 32'(n), 32'd4);
        chk({tag, " product"}, 32'(out_p), 32'(a * b));
        for (int i = 0; i < stall; i++) begin
            step();
            chk({tag, " stall valid"}, 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, " back to idle"}, 32'(in_ready), 32'd1);
    endtask

    task automatic run8(input int a, input int b);
        int n;
        in_a8 = 8'(a); in_b8 = 8'(b); in_valid8 = 1'b1; out_ready8 = 1'b1;
        step();
        in_valid8 = 1'b0;
        n = 0;
        while (!out_valid8 && n < 30) begin
            step();
            n++;
        end
        chk("w8 latency", 32'(n), 32'd8);
        chk("w8 product", 32'(out_p8), 32'(a * b));
        step();
        chk("w8 idle", 32'(in_ready8), 32'd1);
    endtask

    initial begin
        int exp_valid;
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
        in_valid8 = 1'b0; out_ready8 = 1'b0; in_a8 = '0; in_b8 = '0;

        // reset state
        repeat (3) step();
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out", 32'(out_p), 32'd0);
        rst_n = 1'b1;
        step();

        // directed products
        run4(9, 13, 0, "9x13");
        chk("9x13 held after handoff", 32'(out_p), 32'd117);
        run4(15, 15, 0, "15x15");
        run4(0, 11, 0, "0x11");
        run4(1, 15, 0, "1x15");

        // backpressure: hold in DONE for 10 cycles while new operands are offered
        in_a = 4'd5; in_b = 4'd6; in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        chk("bp first valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            in_a = 4'(i); in_b = 4'(15 - i);
            step();
            chk("bp valid held", 32'(out_valid), 32'd1);
            chk("bp out stable", 32'(out_p), 32'd30);
            chk("bp in_ready low", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp release valid", 32'(out_valid), 32'd0);
        chk("bp release ready", 32'(in_ready), 32'd1);

        // reset after two RUN steps
        in_a = 4'd9; in_b = 4'd13; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (2) step();
        rst_n = 1'b0;
        #1;
        chk("mid reset in_ready", 32'(in_ready), 32'd1);
        chk("mid reset out_valid", 32'(out_valid), 32'd0);
        chk("mid reset out", 32'(out_p), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        run4(7, 6, 0, "7x6 after reset");

        // back-to-back with in_valid and out_ready tied high
        in_a = 4'd3; in_b = 4'd5; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_a = 4'd12; in_b = 4'd10;
        for (int i = 1; i <= 11; i++) begin
            step();
            exp_valid = (i == 4 || i == 10) ? 1 : 0;
            chk("b2b valid pulse", 32'(out_valid), 32'(exp_valid));
            if (i == 4) chk("b2b first", 32'(out_p), 32'd15);
            if (i == 10) chk("b2b second", 32'(out_p), 32'd120);
            chk("b2b exclusive", 32'(in_ready & out_valid), 32'd0);
        end
        in_valid = 1'b0; out_ready = 1'b0;
        step();

        // exhaustive WIDTH=4 with random stalls
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                run4(a, b, int'($urandom_range(0, 2)), "exh");

        // random sweep at WIDTH=8, including the extremes
        run8(255, 255);
        run8(0, 255);
        for (int i = 0; i < 40; i++)
            run8(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
